ir_decode_queue: RTL and testbench
==================================

# ir_decode_queue

Parametrised instruction-register stage for the 16-bit core: accepts fetched instruction words over a valid/ready handshake and decodes each into ar/br/fcode/d fields at push time. Decoded entries are held in a DEPTH-entry circular queue, so fetch can run ahead of execute. The queue head is presented to the execute stage with its own valid/ready handshake. A flush input discards all queued entries on a branch.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- DW, 16: width of out_d.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_instr holds a fetched instruction.
- in_instr  in  16  raw instruction word.
- in_ready  out  1  queue can accept; equals (count < DEPTH); no combinational path from out_ready.
- flush  in  1  discard all entries this cycle.
- out_ready  in  1  execute consumes head.
- out_valid  out  1  head entry valid (count ≠ 0).
- out_fmt  out  2  in_instr[15:14] of head.
- out_ar  out  3  register A field.
- out_br  out  3  register B field.
- out_fcode  out  4  function code.
- out_d  out  DW  immediate/displacement.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Decode per in_instr[15:14], performed on push; the decoded fields are stored, not the raw word:
  - 11 (ALU): ar=[13:11], br=[10:8], fcode=[7:4], d=zero-extended [3:0].
  - 00 (load): ar=[13:11], br=[10:8], fcode=4'h0, d=ext([7:0]).
  - 01 (store): ar=[13:11], br=[10:8], fcode=4'h1, d=ext([7:0]).
  - 10 (branch/imm): ar=3'b000, br=[10:8], fcode=zero-extended [13:11], d=ext([7:0]).
- ext() is zero-extension, or sign-extension when the configuration macro is defined.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Write and read pointers wrap modulo DEPTH.
- Push and pop in the same cycle: both occur and count is unchanged. When full, in_ready=0, so a simultaneous pop does not admit a push that cycle.
- Flush: count, rd_ptr and wr_ptr go to 0. Any push and pop in the same cycle are ignored, and the pushed word is lost.
- When out_valid=0, all out_* fields are driven to 0. Stale entry contents are never visible.

## Timing
- Reset values: count=0, pointers=0, out_valid=0, in_ready=1, and all fields 0. Entry storage does not need a reset.
- Latency: a word pushed at edge N appears at the outputs after edge N (1 cycle), including when the queue was empty.
- Outputs are driven from registered state only. The head is a mux of the stored entry addressed by rd_ptr.
- Asserting rst mid-operation clears the queue immediately and asynchronously. The first push is accepted on the first edge after rst is released.
- Flush takes effect at the edge. out_valid=0 and in_ready=1 in the following cycle.

## Configuration
- IR_SIGN_EXT_EN defined: ext() sign-extends [7:0] to DW for formats 00/01/10.
- IR_SIGN_EXT_EN undefined: ext() zero-extends.
- Format 11 d is always zero-extended.
- When DW=8 the macro has no effect.

## Structure
- Package ir_pkg holds:
  - Format constants FMT_ALU=2'b11, FMT_LD=2'b00, FMT_ST=2'b01, FMT_BR=2'b10.
  - Fcode constants FC_LD=4'h0, FC_ST=4'h1.
  - A decoded-entry struct {fmt, ar, br, fcode, d}.
- Sub-module ir_field_decode is purely combinational: 16-bit word in, decoded struct out. It is instantiated once, on the push path.
- Top level contains the storage array, the pointers, count and the handshake logic.

## Test plan
- Reset, then push 16'hC9A5 -> the next cycle shows out_valid=1, fmt=11, ar=1, br=1, fcode=A, d=0005.
- Push 16'h0AF0 with IR_SIGN_EXT_EN defined, DW=16 -> ar=1, br=2, fcode=0, d=FFF0. With the macro undefined -> d=00F0.
- Push 16'h9B7F -> ar=0, br=3, fcode=3, d=007F.
- Hold out_ready=0 and push DEPTH words -> count=DEPTH and in_ready=0. Then pop one -> in_ready=1 in the next cycle and entries emerge in push order across pointer wrap.
- Raise flush together with in_valid and out_ready while count=3 -> the next cycle has count=0 and out_valid=0, and the pushed word never appears.
- With count=2, push and pop continuously for 10 cycles -> count stays 2 and the output order matches the input order.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the instruction-register decode queue.
package ir_pkg;

  localparam logic [1:0] FMT_ALU = 2'b11;
  localparam logic [1:0] FMT_LD  = 2'b00;
  localparam logic [1:0] FMT_ST  = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;

  localparam logic [3:0] FC_LD = 4'h0;
  localparam logic [3:0] FC_ST = 4'h1;

  // Stored displacement width; the queue presents the low DW bits (DW <= 16).
  localparam int IR_D_W = 16;

  typedef struct packed {
    logic [1:0]        fmt;
    logic [2:0]        ar;
    logic [2:0]        br;
    logic [3:0]        fcode;
    logic [IR_D_W-1:0] d;
  } ir_entry_t;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational instruction-word decoder on the push path.
// IR_SIGN_EXT_EN: sign-extend the 8-bit displacement of formats 00/01/10.
module ir_field_decode
  import ir_pkg::*;
(
  input  logic [15:0] instr,
  output ir_entry_t   entry
);

  logic [IR_D_W-1:0] ext_d;

`ifdef IR_SIGN_EXT_EN
  assign ext_d = {{(IR_D_W-8){instr[7]}}, instr[7:0]};
`else
  assign ext_d = {{(IR_D_W-8){1'b0}}, instr[7:0]};
`endif

  always_comb begin
    entry       = '0;
    entry.fmt   = instr[15:14];
    entry.ar    = instr[13:11];
    entry.br    = instr[10:8];
    entry.d     = ext_d;
    case (instr[15:14])
      FMT_ALU: begin
        entry.fcode = instr[7:4];
        entry.d     = {{(IR_D_W-4){1'b0}}, instr[3:0]};
      end
      FMT_LD:  entry.fcode = FC_LD;
      FMT_ST:  entry.fcode = FC_ST;
      FMT_BR: begin
        entry.ar    = 3'b000;
        entry.fcode = {1'b0, instr[13:11]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ir_decode_queue.sv
// Decode-at-push instruction queue with valid/ready on both sides and branch flush.
// Optional IR_SIGN_EXT_EN (see ir_field_decode) selects signed displacements.
module ir_decode_queue
  import ir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [15:0]                  in_instr,
  output logic                         in_ready,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [1:0]                   out_fmt,
  output logic [2:0]                   out_ar,
  output logic [2:0]                   out_br,
  output logic [3:0]                   out_fcode,
  output logic [DW-1:0]                out_d,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  ir_entry_t       mem [DEPTH];
  ir_entry_t       dec;
  ir_entry_t       head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  ir_field_decode u_decode (
    .instr (in_instr),
    .entry (dec)
  );

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  // A flush wins over both handshakes in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  // Empty queue forces all fields to zero so stale entries never leak out.
  assign head      = mem[rd_ptr];
  assign out_fmt   = out_valid ? head.fmt   : '0;
  assign out_ar    = out_valid ? head.ar    : '0;
  assign out_br    = out_valid ? head.br    : '0;
  assign out_fcode = out_valid ? head.fcode : '0;
  assign out_d     = out_valid ? head.d[DW-1:0] : '0;

endmodule

// File: tb/tb_ir_decode_queue.sv
// Randomised bench for ir_decode_queue against a queue-based reference model.
module tb_ir_decode_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 16;

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  ar;
    logic [2:0]  br;
    logic [3:0]  fcode;
    logic [15:0] d;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 0;
  logic        out_ready = 0;
  logic        out_valid;
  logic [1:0]  out_fmt;
  logic [2:0]  out_ar;
  logic [2:0]  out_br;
  logic [3:0]  out_fcode;
  logic [DW-1:0] out_d;
  logic [$clog2(DEPTH+1)-1:0] count;

  int n_checks = 0;
  int n_errors = 0;
  exp_t model_q[$];

  ir_decode_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_fmt(out_fmt), .out_ar(out_ar), .out_br(out_br),
    .out_fcode(out_fcode), .out_d(out_d), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_decode(input logic [15:0] w);
    exp_t e;
    int lo;
    lo = int'(w[7:0]);
`ifdef IR_SIGN_EXT_EN
    if (lo >= 128) lo = lo - 256;
`endif
    e.fmt = w[15:14];
    e.ar  = w[13:11];
    e.br  = w[10:8];
    e.d   = 16'(lo);
    case (int'(w[15:14]))
      3: begin e.fcode = w[7:4]; e.d = 16'(int'(w[3:0])); end
      0: e.fcode = 4'd0;
      1: e.fcode = 4'd1;
      default: begin e.ar = 3'd0; e.fcode = 4'(int'(w[13:11])); end
    endcase
    return e;
  endfunction

  task automatic check_outputs(input string tag);
    exp_t h;
    h = '{fmt: 2'd0, ar: 3'd0, br: 3'd0, fcode: 4'd0, d: 16'd0};
    if (model_q.size() != 0) h = model_q[0];
    chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
    chk({tag, "_valid"}, 32'(out_valid), 32'(model_q.size() != 0));
    chk({tag, "_ready"}, 32'(in_ready), 32'(model_q.size() < DEPTH));
    chk({tag, "_fmt"},   32'(out_fmt),   32'(h.fmt));
    chk({tag, "_ar"},    32'(out_ar),    32'(h.ar));
    chk({tag, "_br"},    32'(out_br),    32'(h.br));
    chk({tag, "_fcode"}, 32'(out_fcode), 32'(h.fcode));
    chk({tag, "_d"},     32'(out_d),     32'(h.d));
  endtask

  // Called 1 time unit after a rising edge; applies inputs, clocks once, checks.
  task automatic step(input string tag, input logic v, input logic [15:0] w,
                      input logic r, input logic f);
    bit do_push, do_pop;
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
    flush     = f;
    do_push = v && (model_q.size() < DEPTH) && !f;
    do_pop  = r && (model_q.size() != 0) && !f;
    @(posedge clk);
    #1;
    if (f) model_q.delete();
    else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(model_decode(w));
    end
    in_valid = 0; out_ready = 0; flush = 0;
    check_outputs(tag);
  endtask

  initial begin
    logic [15:0] d_exp;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 0;

    step("push_c9a5", 1, 16'hC9A5, 0, 0);
    chk("c9a5_valid", 32'(out_valid), 32'd1);
    chk("c9a5_fmt", 32'(out_fmt), 32'h3);
    chk("c9a5_ar", 32'(out_ar), 32'h1);
    chk("c9a5_br", 32'(out_br), 32'h1);
    chk("c9a5_fcode", 32'(out_fcode), 32'hA);
    chk("c9a5_d", 32'(out_d), 32'h0005);
    step("pop1", 0, 16'h0, 1, 0);

    step("push_0af0", 1, 16'h0AF0, 0, 0);
`ifdef IR_SIGN_EXT_EN
    d_exp = 16'hFFF0;
`else
    d_exp = 16'h00F0;
`endif
    chk("0af0_ar", 32'(out_ar), 32'h1);
    chk("0af0_br", 32'(out_br), 32'h2);
    chk("0af0_fcode", 32'(out_fcode), 32'h0);
    chk("0af0_d", 32'(out_d), 32'(d_exp));
    step("pop2", 0, 16'h0, 1, 0);

    step("push_9b7f", 1, 16'h9B7F, 0, 0);
    chk("9b7f_ar", 32'(out_ar), 32'h0);
    chk("9b7f_br", 32'(out_br), 32'h3);
    chk("9b7f_fcode", 32'(out_fcode), 32'h3);
    chk("9b7f_d", 32'(out_d), 32'h007F);
    step("pop3", 0, 16'h0, 1, 0);

    // Fill, then pop while offering a push that must be refused.
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 16'($urandom), 0, 0);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_ready", 32'(in_ready), 32'd0);
    step("pop_full", 1, 16'hFFFF, 1, 0);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) step("wrap", (i < 3) ? 1'b1 : 1'b0, 16'($urandom), 1, 0);

    // Flush with simultaneous push and pop at count=3.
    for (int i = 0; i < 3; i++) step("pre_flush", 1, 16'($urandom), 0, 0);
    chk("pre_flush_count", 32'(count), 32'd3);
    step("flush", 1, 16'h1234, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);

    // Steady-state push+pop at count=2.
    step("s0", 1, 16'($urandom), 0, 0);
    step("s1", 1, 16'($urandom), 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("steady", 1, 16'($urandom), 1, 0);
      chk("steady_count", 32'(count), 32'd2);
    end

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 2; i++) step("pre_rst", 1, 16'($urandom), 0, 0);
    rst = 1;
    #2;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_d", 32'(out_d), 32'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    step("post_rst_push", 1, 16'h4321, 0, 0);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
